step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter STEP_W, default 16, width of step counts.
REQ-002 SHALL have parameter DATA_W, default 32, command payload width.
REQ-003 SHALL have parameter WD_W, default 24, watchdog counter width.
REQ-004 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  in  1  asynchronous, active-high reset.
REQ-006 Port cmd_valid  in  1  host command present.
REQ-007 Port cmd_ready  out  1  command accepted this cycle when high with cmd_valid.
REQ-008 Port cmd_op  in  2  opcode: 0 NOP, 1 SET_STEPS, 2 SET_WD_LIMIT, 3 START.
REQ-009 Port cmd_data  in  DATA_W  payload; low STEP_W bits for SET_STEPS, low WD_W bits for SET_WD_LIMIT.
REQ-010 Port pusher_done  in  1  one-cycle pulse marking completion of one push/scatter timestep.
REQ-011 Port ui_done  out  1  one-cycle pulse launching a run.
REQ-012 Port last_step  out  1  high while the current timestep is the final one.
REQ-013 Port step_count  out  STEP_W  completed timesteps in current/last run.
REQ-014 Port num_steps  out  STEP_W  programmed run length.
REQ-015 Port busy  out  1  high from START acceptance until run completes.
REQ-016 Port run_complete  out  1  one-cycle pulse when final pusher_done is consumed.
REQ-017 Port cfg_error  out  1  sticky; set on START with num_steps==0.
REQ-018 Port wd_timeout  out  1  sticky watchdog flag (tied 0 when watchdog compiled out).

Function
REQ-019 SHALL implement states IDLE, LAUNCH, RUN, FINISH.
REQ-020 cmd_ready SHALL be 1 in IDLE only; commands in other states SHALL stall, not drop.
REQ-021 IDLE: SET_STEPS loads num_steps; SET_WD_LIMIT loads wd_limit; NOP no effect; each takes one accepted cycle.
REQ-022 IDLE: START with num_steps!=0 SHALL clear step_count and cfg_error, set busy, go to LAUNCH.
REQ-023 IDLE: START with num_steps==0 SHALL set cfg_error, remain IDLE, emit no ui_done.
REQ-024 LAUNCH SHALL assert ui_done for exactly one cycle then go to RUN; ui_done is registered, asserted the cycle after START is accepted.
REQ-025 RUN: each pusher_done pulse SHALL increment step_count by 1.
REQ-026 last_step SHALL be combinationally (step_count == num_steps-1) AND state==RUN, so it is valid in the cycle pusher_done arrives.
REQ-027 RUN: pusher_done while last_step SHALL increment step_count, go to FINISH.
REQ-028 FINISH SHALL pulse run_complete one cycle, clear busy, go to IDLE.
REQ-029 pusher_done outside RUN SHALL be ignored.
REQ-030 num_steps SHALL be frozen while busy; step_count SHALL saturate, never wrap.
REQ-031 step_count SHALL hold its final value in IDLE until next valid START.

Reset
REQ-032 rst asserted SHALL immediately force IDLE, num_steps=0, step_count=0, wd_limit=all-ones, and all outputs 0 except cmd_ready=1 after release.
REQ-033 rst mid-run SHALL abort the run without run_complete or ui_done pulses.

Configuration
REQ-034 Macro STEP_SEQUENCER_WATCHDOG_EN SHALL compile in a watchdog.
REQ-035 With macro: WD_W counter clears on entering RUN and on each pusher_done; increments in RUN; on reaching wd_limit sets wd_timeout, goes to FINISH (run_complete pulses, step_count holds).
REQ-036 Without macro: no counter or wd_limit register; SET_WD_LIMIT accepted as NOP; wd_timeout constant 0.

Verification
REQ-037 SET_STEPS 3, START -> ui_done one cycle later; three pusher_done pulses; last_step high only during third; run_complete one cycle after third; step_count=3.
REQ-038 SET_STEPS 0, START -> cfg_error=1, no ui_done, busy=0, cmd_ready stays 1.
REQ-039 SET_STEPS 1, START -> last_step high throughout RUN; single pusher_done ends run; step_count=1.
REQ-040 START then cmd_valid SET_STEPS 9 held during run -> cmd_ready=0 until IDLE; num_steps stays at prior value, updates to 9 the cycle after return to IDLE.
REQ-041 SET_STEPS 5, after 2 pusher_done assert rst -> all outputs 0 same cycle, no run_complete; fresh START restarts at step_count=0.
REQ-042 With STEP_SEQUENCER_WATCHDOG_EN, SET_WD_LIMIT 10, SET_STEPS 4, START, no pusher_done -> wd_timeout=1 after 10 RUN cycles, run_complete pulses, step_count=0.

Source files
------------

// File: rtl/step_sequencer.sv
// Timestep sequencer: takes host commands, launches a run, then counts pusher_done pulses to the programmed length.
// Optional watchdog compiled in with `define STEP_SEQUENCER_WATCHDOG_EN.
module step_sequencer #(
  parameter int STEP_W = 16,
  parameter int DATA_W = 32,
  parameter int WD_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              pusher_done,
  output logic              ui_done,
  output logic              last_step,
  output logic [STEP_W-1:0] step_count,
  output logic [STEP_W-1:0] num_steps,
  output logic              busy,
  output logic              run_complete,
  output logic              cfg_error,
  output logic              wd_timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP       = 2'd0;
  localparam logic [1:0] OP_SET_STEPS = 2'd1;
  localparam logic [1:0] OP_SET_WD    = 2'd2;
  localparam logic [1:0] OP_START     = 2'd3;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] num_steps_q, num_steps_d;
  logic [STEP_W-1:0] step_count_q, step_count_d;
  logic              cfg_error_q, cfg_error_d;
  logic              ui_done_q, ui_done_d;
  logic              run_complete_q, run_complete_d;
  logic              busy_q, busy_d;
  logic              cmd_accept;
  logic              last_step_c;

  // Only bits up to STEP_W/WD_W of the payload are meaningful.
  logic unused_cmd_data;
  assign unused_cmd_data = ^cmd_data;

`ifdef STEP_SEQUENCER_WATCHDOG_EN
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [WD_W-1:0] wd_limit_q, wd_limit_d;
  logic [WD_W-1:0] wd_cnt_inc;
  logic            wd_timeout_q, wd_timeout_d;
  assign wd_cnt_inc = wd_cnt_q + WD_W'(1);
`endif

  assign cmd_accept  = cmd_valid && (state_q == S_IDLE);
  assign last_step_c = (state_q == S_RUN) && (step_count_q == num_steps_q - STEP_W'(1));

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    num_steps_d    = num_steps_q;
    step_count_d   = step_count_q;
    cfg_error_d    = cfg_error_q;
    busy_d         = busy_q;
    ui_done_d      = 1'b0;
    run_complete_d = 1'b0;
`ifdef STEP_SEQUENCER_WATCHDOG_EN
    wd_cnt_d       = wd_cnt_q;
    wd_limit_d     = wd_limit_q;
    wd_timeout_d   = wd_timeout_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          unique case (cmd_op)
            OP_NOP:       ;
            OP_SET_STEPS: num_steps_d = cmd_data[STEP_W-1:0];
            OP_SET_WD: begin
`ifdef STEP_SEQUENCER_WATCHDOG_EN
              wd_limit_d = cmd_data[WD_W-1:0];
`endif
            end
            OP_START: begin
              if (num_steps_q == '0) begin
                cfg_error_d = 1'b1;
              end else begin
                step_count_d = '0;
                cfg_error_d  = 1'b0;
                busy_d       = 1'b1;
                ui_done_d    = 1'b1;
                state_d      = S_LAUNCH;
              end
            end
          endcase
        end
      end
      S_LAUNCH: begin
        state_d = S_RUN;
`ifdef STEP_SEQUENCER_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end
      S_RUN: begin
        if (pusher_done) begin
          if (step_count_q != '1) step_count_d = step_count_q + STEP_W'(1);
`ifdef STEP_SEQUENCER_WATCHDOG_EN
          wd_cnt_d = '0;
`endif
          if (last_step_c) begin
            run_complete_d = 1'b1;
            state_d        = S_FINISH;
          end
        end
`ifdef STEP_SEQUENCER_WATCHDOG_EN
        else begin
          wd_cnt_d = wd_cnt_inc;
          if (wd_cnt_inc == wd_limit_q) begin
            wd_timeout_d   = 1'b1;
            run_complete_d = 1'b1;
            state_d        = S_FINISH;
          end
        end
`endif
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      num_steps_q    <= '0;
      step_count_q   <= '0;
      cfg_error_q    <= 1'b0;
      busy_q         <= 1'b0;
      ui_done_q      <= 1'b0;
      run_complete_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      num_steps_q    <= num_steps_d;
      step_count_q   <= step_count_d;
      cfg_error_q    <= cfg_error_d;
      busy_q         <= busy_d;
      ui_done_q      <= ui_done_d;
      run_complete_q <= run_complete_d;
    end
  end

`ifdef STEP_SEQUENCER_WATCHDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q     <= '0;
      wd_limit_q   <= '1;
      wd_timeout_q <= 1'b0;
    end else begin
      wd_cnt_q     <= wd_cnt_d;
      wd_limit_q   <= wd_limit_d;
      wd_timeout_q <= wd_timeout_d;
    end
  end
  assign wd_timeout = wd_timeout_q;
`else
  assign wd_timeout = 1'b0;
`endif

  // Ready is held low while reset is asserted so every output reads 0 during reset.
  assign cmd_ready    = (state_q == S_IDLE) && !rst;
  assign ui_done      = ui_done_q;
  assign last_step    = last_step_c;
  assign step_count   = step_count_q;
  assign num_steps    = num_steps_q;
  assign busy         = busy_q;
  assign run_complete = run_complete_q;
  assign cfg_error    = cfg_error_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: scoreboard of expected run results checked on each run_complete pulse.
// Watchdog scenario is built when STEP_SEQUENCER_WATCHDOG_EN is defined.
module tb_step_sequencer;

  localparam int STEP_W = 16;
  localparam int DATA_W = 32;
  localparam int WD_W   = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              pusher_done;
  logic              ui_done;
  logic              last_step;
  logic [STEP_W-1:0] step_count;
  logic [STEP_W-1:0] num_steps;
  logic              busy;
  logic              run_complete;
  logic              cfg_error;
  logic              wd_timeout;

  typedef struct {
    int   steps;
    logic wd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   ui_seen = 0;
  int   ui_exp  = 0;

  always #5 clk = ~clk;

  step_sequencer #(.STEP_W(STEP_W), .DATA_W(DATA_W), .WD_W(WD_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .pusher_done(pusher_done),
    .ui_done(ui_done), .last_step(last_step), .step_count(step_count),
    .num_steps(num_steps), .busy(busy), .run_complete(run_complete),
    .cfg_error(cfg_error), .wd_timeout(wd_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the command until ready, then lets it be accepted on the next edge.
  task automatic send_cmd(input logic [1:0] op, input int data);
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = DATA_W'(data);
    while (!cmd_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
  endtask

  task automatic pulse_pd(input string tag, input logic exp_last);
    pusher_done = 1'b1;
    check(tag, 64'(last_step), 64'(exp_last));
    tick();
    pusher_done = 1'b0;
  endtask

  // Scoreboard consumer: every run_complete must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && run_complete) begin
      if (exp_q.size() == 0) begin
        check("unexpected_run_complete", 64'(run_complete), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_step_count", 64'(step_count), 64'(e.steps));
        check("sb_wd_timeout", 64'(wd_timeout), 64'(e.wd));
        check("sb_busy_in_finish", 64'(busy), 64'd1);
      end
    end
    if (!rst && ui_done) ui_seen++;
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0; pusher_done = 1'b0;
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("post_rst_num_steps", 64'(num_steps), 64'd0);
    check("post_rst_step_count", 64'(step_count), 64'd0);
    check("post_rst_outputs", 64'({ui_done, last_step, busy, run_complete, cfg_error, wd_timeout}), 64'd0);

    // Three-step run.
    send_cmd(2'd1, 3);
    check("set_steps_3", 64'(num_steps), 64'd3);
    exp_q.push_back('{steps: 3, wd: 1'b0});
    ui_exp++;
    send_cmd(2'd3, 0);
    check("launch_ui_done", 64'(ui_done), 64'd1);
    check("launch_busy", 64'(busy), 64'd1);
    check("launch_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    check("run_ui_done_low", 64'(ui_done), 64'd0);
    check("run_step_count0", 64'(step_count), 64'd0);
    pulse_pd("r3_last_1", 1'b0);
    check("r3_count1", 64'(step_count), 64'd1);
    tick();
    pulse_pd("r3_last_2", 1'b0);
    pulse_pd("r3_last_3", 1'b1);
    check("r3_run_complete", 64'(run_complete), 64'd1);
    check("r3_last_in_finish", 64'(last_step), 64'd0);
    tick();
    check("r3_idle_busy", 64'(busy), 64'd0);
    check("r3_idle_rc", 64'(run_complete), 64'd0);
    pulse_pd("idle_pd_last", 1'b0);
    check("idle_pd_ignored", 64'(step_count), 64'd3);

    // Zero-length start is a configuration error.
    send_cmd(2'd1, 0);
    send_cmd(2'd3, 0);
    check("zero_cfg_error", 64'(cfg_error), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    check("zero_ui_count", 64'(ui_seen), 64'(ui_exp));
    check("zero_count_held", 64'(step_count), 64'd3);

    // Single-step run: last_step is high throughout RUN.
    send_cmd(2'd1, 1);
    exp_q.push_back('{steps: 1, wd: 1'b0});
    ui_exp++;
    send_cmd(2'd3, 0);
    check("one_cfg_error_cleared", 64'(cfg_error), 64'd0);
    check("one_count_cleared", 64'(step_count), 64'd0);
    check("one_last_in_launch", 64'(last_step), 64'd0);
    tick();
    check("one_last_a", 64'(last_step), 64'd1);
    tick();
    check("one_last_b", 64'(last_step), 64'd1);
    pulse_pd("one_last_pd", 1'b1);
    check("one_count", 64'(step_count), 64'd1);
    tick();

    // Commands stall while busy; num_steps frozen.
    send_cmd(2'd1, 2);
    exp_q.push_back('{steps: 2, wd: 1'b0});
    ui_exp++;
    send_cmd(2'd3, 0);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = DATA_W'(9);
    check("stall_ready_launch", 64'(cmd_ready), 64'd0);
    tick();
    check("stall_ready_run", 64'(cmd_ready), 64'd0);
    pulse_pd("stall_last_1", 1'b0);
    pulse_pd("stall_last_2", 1'b1);
    check("stall_ready_finish", 64'(cmd_ready), 64'd0);
    check("stall_num_frozen", 64'(num_steps), 64'd2);
    tick();
    check("stall_ready_idle", 64'(cmd_ready), 64'd1);
    check("stall_num_not_yet", 64'(num_steps), 64'd2);
    tick();
    check("stall_num_updated", 64'(num_steps), 64'd9);
    cmd_valid = 1'b0; cmd_op = 2'd0;

    // Reset mid-run aborts without completion.
    send_cmd(2'd1, 5);
    ui_exp++;
    send_cmd(2'd3, 0);
    tick();
    pulse_pd("abort_last_1", 1'b0);
    pulse_pd("abort_last_2", 1'b0);
    check("abort_count2", 64'(step_count), 64'd2);
    rst = 1'b1;
    #1;
    check("abort_outputs", 64'({ui_done, last_step, busy, run_complete, cfg_error, wd_timeout, cmd_ready}), 64'd0);
    check("abort_count", 64'(step_count), 64'd0);
    check("abort_num", 64'(num_steps), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("abort_ready", 64'(cmd_ready), 64'd1);
    send_cmd(2'd1, 2);
    exp_q.push_back('{steps: 2, wd: 1'b0});
    ui_exp++;
    send_cmd(2'd3, 0);
    check("restart_count0", 64'(step_count), 64'd0);
    tick();
    pulse_pd("restart_last_1", 1'b0);
    tick(); tick(); tick(); tick(); tick();
    pulse_pd("restart_last_2", 1'b1);
    tick();

`ifdef STEP_SEQUENCER_WATCHDOG_EN
    // Watchdog fires after ten RUN cycles without progress.
    send_cmd(2'd2, 10);
    send_cmd(2'd1, 4);
    exp_q.push_back('{steps: 0, wd: 1'b1});
    ui_exp++;
    send_cmd(2'd3, 0);
    tick();
    for (int i = 0; i < 9; i++) tick();
    check("wd_not_yet", 64'(wd_timeout), 64'd0);
    check("wd_still_busy", 64'(busy), 64'd1);
    tick();
    check("wd_timeout", 64'(wd_timeout), 64'd1);
    check("wd_run_complete", 64'(run_complete), 64'd1);
    check("wd_count", 64'(step_count), 64'd0);
    tick();
    check("wd_sticky", 64'(wd_timeout), 64'd1);
    check("wd_idle_busy", 64'(busy), 64'd0);
`else
    // Without the watchdog, SET_WD_LIMIT is a NOP and long gaps never time out.
    send_cmd(2'd2, 3);
    check("nowd_num_kept", 64'(num_steps), 64'd2);
    exp_q.push_back('{steps: 2, wd: 1'b0});
    ui_exp++;
    send_cmd(2'd3, 0);
    tick();
    for (int i = 0; i < 8; i++) tick();
    check("nowd_busy", 64'(busy), 64'd1);
    pulse_pd("nowd_last_1", 1'b0);
    for (int i = 0; i < 8; i++) tick();
    pulse_pd("nowd_last_2", 1'b1);
    tick();
    check("nowd_timeout", 64'(wd_timeout), 64'd0);
`endif

    tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("ui_done_count", 64'(ui_seen), 64'(ui_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
